// File: rtl/latch_bank.sv
// Bank of CH gated W-bit channel registers with a global timed snapshot freeze.
// Define LATCH_BANK_VIOL_EN to build in the sticky setup/hold violation flags.
module latch_bank #(
  parameter int W        = 8,
  parameter int CH       = 4,
  parameter int HOLD_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] data_in,
  input  logic [CH-1:0]   gate,
  input  logic            snap_req,
  input  logic            viol_clr,
  output logic [CH*W-1:0] q,
  output logic [CH*W-1:0] qb,
  output logic            snap_busy,
  output logic            snap_ack,
  output logic [CH-1:0]   viol
);

  localparam int CW = $clog2(HOLD_CYC + 1);

  logic [CH*W-1:0] r_q;
  logic [CH-1:0]   r_gate_q;
  logic [CW-1:0]   r_cnt;
  logic            r_snap_busy;
  logic            r_snap_ack;
  logic            w_snap_start;
  logic            w_hold_all;

  // A request in the ack cycle is dropped so back-to-back freezes always have a gap.
  assign w_snap_start = snap_req & ~r_snap_busy & ~r_snap_ack;
  assign w_hold_all   = r_snap_busy | w_snap_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_gate_q <= '0;
    end else begin
      r_gate_q <= gate;
      for (int k = 0; k < CH; k++) begin
        if (!w_hold_all && gate[k]) begin
          r_q[k*W +: W] <= data_in[k*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_snap_busy <= 1'b0;
      r_snap_ack  <= 1'b0;
    end else begin
      r_snap_ack <= 1'b0;
      if (r_snap_busy) begin
        if (r_cnt == '0) begin
          r_snap_busy <= 1'b0;
          r_snap_ack  <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end else if (w_snap_start) begin
        r_snap_busy <= 1'b1;
        r_cnt       <= CW'(HOLD_CYC - 1);
      end
    end
  end

`ifdef LATCH_BANK_VIOL_EN
  logic [CH-1:0] r_viol;
  logic [CH-1:0] r_fall_q;
  logic [CH-1:0] w_fall;
  logic [CH-1:0] w_diff;
  logic [CH-1:0] w_set;

  always_comb begin
    w_diff = '0;
    for (int k = 0; k < CH; k++) begin
      w_diff[k] = (data_in[k*W +: W] != r_q[k*W +: W]);
    end
  end

  // Setup: data moving on the closing edge; hold: data moving one cycle later.
  assign w_fall = r_gate_q & ~gate & {CH{~r_snap_busy}};
  assign w_set  = (w_fall | r_fall_q) & w_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_viol   <= '0;
      r_fall_q <= '0;
    end else begin
      r_fall_q <= w_fall;
      r_viol   <= (r_viol & ~{CH{viol_clr}}) | w_set;
    end
  end

  assign viol = r_viol;
`else
  logic w_unused;
  assign w_unused = viol_clr | (|r_gate_q);
  assign viol     = '0;
`endif

  assign q         = r_q;
  assign qb        = ~r_q;
  assign snap_busy = r_snap_busy;
  assign snap_ack  = r_snap_ack;

endmodule

// File: tb/tb_latch_bank.sv
// Randomized and directed checks of latch_bank against a cycle-level behavioural model.
module tb_latch_bank;

  localparam int W        = 8;
  localparam int CH       = 4;
  localparam int HOLD_CYC = 4;
`ifdef LATCH_BANK_VIOL_EN
  localparam bit VIOL_ON = 1'b1;
`else
  localparam bit VIOL_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] data_in;
  logic [CH-1:0]   gate;
  logic            snap_req;
  logic            viol_clr;
  logic [CH*W-1:0] q;
  logic [CH*W-1:0] qb;
  logic            snap_busy;
  logic            snap_ack;
  logic [CH-1:0]   viol;

  latch_bank #(.W(W), .CH(CH), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .gate(gate), .snap_req(snap_req),
    .viol_clr(viol_clr), .q(q), .qb(qb), .snap_busy(snap_busy),
    .snap_ack(snap_ack), .viol(viol)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: channel values, freeze cycles remaining, pending ack.
  logic [W-1:0] m_q [CH];
  int           m_left;
  bit           m_ack;
  bit [CH-1:0]  m_gate_prev;
  bit [CH-1:0]  m_fall_prev;
  bit [CH-1:0]  m_viol;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [CH*W-1:0] m_q_packed();
    logic [CH*W-1:0] v;
    for (int k = 0; k < CH; k++) v[k*W +: W] = m_q[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) m_q[k] = '0;
    m_left = 0; m_ack = 1'b0;
    m_gate_prev = '0; m_fall_prev = '0; m_viol = '0;
  endtask

  task automatic model_edge();
    bit busy, start, fall, diff;
    bit [CH-1:0] nfall, nviol;
    logic [W-1:0] dk;
    if (rst) begin
      model_reset();
    end else begin
      busy  = (m_left > 0);
      start = !busy && !m_ack && snap_req;
      nfall = '0; nviol = '0;
      for (int k = 0; k < CH; k++) begin
        dk   = data_in[k*W +: W];
        diff = (dk != m_q[k]);
        fall = !busy && m_gate_prev[k] && !gate[k];
        nfall[k] = fall;
        nviol[k] = ((fall || m_fall_prev[k]) && diff) || (m_viol[k] && !viol_clr);
        if (!busy && !start && gate[k]) m_q[k] = dk;
      end
      m_ack = busy && (m_left == 1);
      if (start) m_left = HOLD_CYC;
      else if (busy) m_left = m_left - 1;
      m_gate_prev = gate;
      m_fall_prev = nfall;
      m_viol      = VIOL_ON ? nviol : '0;
    end
  endtask

  task automatic compare_all();
    logic [CH*W-1:0] eq, eqb;
    eq  = m_q_packed();
    eqb = ~eq;
    chk("q", q, eq);
    chk("qb", qb, eqb);
    chk("busy", snap_busy, m_left > 0);
    chk("ack", snap_ack, m_ack);
    chk("viol", viol, m_viol);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; gate = '0; data_in = '0; snap_req = 1'b0; viol_clr = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [CH*W-1:0] d0, qexp;
    logic [CH-1:0]   vexp;
    rst = 1'b1; gate = '0; data_in = '0; snap_req = 1'b0; viol_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_qb", qb, 32'hFFFF_FFFF);
    chk("rst_busy", snap_busy, 1'b0);
    chk("rst_ack", snap_ack, 1'b0);
    chk("rst_viol", viol, 4'h0);
    tick();
    rst = 1'b0;

    // Single channel tracks, gated-off channels stay at reset value.
    gate = 4'b0001; data_in = 32'h5566_77A5;
    tick();
    chk("ch0_track_q", q, 32'h0000_00A5);
    chk("ch0_track_qb", qb, 32'hFFFF_FF5A);

    // Clean gate close: value held, no violation.
    do_reset();
    gate = 4'b0001; data_in = 32'h0000_003C; tick();
    gate = 4'b0000; tick();
    tick();
    data_in = 32'h0000_0077; tick();
    tick();
    chk("clean_close_q", q, 32'h0000_003C);
    chk("clean_close_viol", viol, 4'h0);

    // Setup violation on ch1, then clear coinciding with a hold violation.
    vexp = VIOL_ON ? 4'b0010 : 4'b0000;
    do_reset();
    gate = 4'b0010; data_in = 32'h0000_1000; tick();
    gate = 4'b0000; data_in = 32'h0000_1100; tick();
    chk("setup_viol", viol, vexp);
    viol_clr = 1'b1; tick();
    chk("set_wins_clr", viol, vexp);
    viol_clr = 1'b0; tick(); tick();
    chk("viol_sticky", viol, vexp);
    viol_clr = 1'b1; tick();
    chk("viol_cleared", viol, 4'h0);
    viol_clr = 1'b0;

    // Timed freeze with gate all-on and toggling data.
    do_reset();
    d0 = 32'hA1B2_C3D4;
    gate = 4'hF; data_in = d0; tick();
    snap_req = 1'b1; data_in = ~d0; tick();
    chk("freeze_start_q", q, d0);
    chk("freeze_start_busy", snap_busy, 1'b1);
    snap_req = 1'b0;
    for (int i = 0; i < HOLD_CYC - 1; i++) begin
      data_in  = (i % 2 == 0) ? d0 ^ 32'h0F0F_0F0F : ~d0;
      snap_req = (i == 1);
      tick();
      chk("freeze_busy", snap_busy, 1'b1);
      chk("freeze_q", q, d0);
      chk("freeze_no_ack", snap_ack, 1'b0);
    end
    snap_req = 1'b0; data_in = 32'h1357_9BDF; tick();
    chk("freeze_end_busy", snap_busy, 1'b0);
    chk("freeze_end_ack", snap_ack, 1'b1);
    chk("freeze_end_q", q, d0);
    snap_req = 1'b1; data_in = 32'h2468_ACE0; tick();
    chk("resume_q", q, 32'h2468_ACE0);
    chk("ack_pulse_once", snap_ack, 1'b0);
    chk("req_in_ack_ignored", snap_busy, 1'b0);
    snap_req = 1'b0;

    // Reset asserted during the second freeze cycle.
    do_reset();
    gate = 4'hF; data_in = 32'h1122_3344; tick();
    snap_req = 1'b1; tick();
    snap_req = 1'b0; tick();
    rst = 1'b1; #1;
    model_reset();
    chk("rst_mid_q", q, 32'h0);
    chk("rst_mid_busy", snap_busy, 1'b0);
    #2 rst = 1'b0;
    for (int i = 0; i < HOLD_CYC + 2; i++) begin
      tick();
      chk("rst_mid_no_ack", snap_ack, 1'b0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 3) == 0) gate[k] = ~gate[k];
        if ($urandom_range(0, 2) == 0) data_in[k*W +: W] = W'($urandom);
      end
      snap_req = ($urandom_range(0, 5) == 0);
      viol_clr = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; snap_req = 1'b0;
    qexp = m_q_packed();
    tick();
    chk("final_q_stable_when_gated", q & ~{{W{gate[3]}}, {W{gate[2]}}, {W{gate[1]}}, {W{gate[0]}}},
        qexp & ~{{W{gate[3]}}, {W{gate[2]}}, {W{gate[1]}}, {W{gate[0]}}});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
